// File: rtl/mem_arbiter.sv
// Arbiter for the shared pipelined main-memory port: sequences I/D block fills,
// issues write-through stores, and hands returned fill words back to the owning cache.
module mem_arbiter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_miss_req,
    input  logic [ADDR_W-1:0]                  i_miss_addr,
    input  logic                               d_miss_req,
    input  logic [ADDR_W-1:0]                  d_miss_addr,
    input  logic                               d_wr_req,
    input  logic [ADDR_W-1:0]                  d_wr_addr,
    input  logic [DATA_W-1:0]                  d_wr_data,
    output logic                               mem_enable,
    output logic                               mem_wr,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [DATA_W-1:0]                  mem_data_out,
    input  logic [DATA_W-1:0]                  mem_data_in,
    input  logic                               mem_data_valid,
    output logic                               i_fill_we,
    output logic                               d_fill_we,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
    output logic [DATA_W-1:0]                  fill_data,
    output logic                               i_fill_done,
    output logic                               d_fill_done,
    output logic                               d_wr_ack,
    output logic                               i_stall,
    output logic                               d_stall
);

    localparam int                WIDX_W     = $clog2(WORDS_PER_BLOCK);
    localparam int                CNT_W      = WIDX_W + 1;
    localparam logic [CNT_W-1:0]  ISSUE_END  = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0]  ISSUE_LAST = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [WIDX_W-1:0] RECV_LAST  = WIDX_W'(WORDS_PER_BLOCK - 1);
    localparam logic [ADDR_W-1:0] BASE_MASK  = ~(ADDR_W'(2 * WORDS_PER_BLOCK - 1));
    localparam logic              OWN_I      = 1'b0;
    localparam logic              OWN_D      = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_owner;
    logic                r_last_owner;
    logic [ADDR_W-1:0]   r_base;
    logic [CNT_W-1:0]    r_issue_cnt;
    logic [WIDX_W-1:0]   r_recv_cnt;
    logic                r_mem_enable;
    logic                r_mem_wr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_data_out;
    logic                r_wr_ack;

    logic                w_grant_fill;
    logic                w_grant_owner;
    logic [ADDR_W-1:0]   w_grant_base;
    logic [CNT_W-1:0]    w_issue_nxt;
    logic [ADDR_W-1:0]   w_issue_addr_nxt;
    logic                w_fill_act;
    logic                w_fill_last;

    // Fill arbitration among pending misses; a tie goes to the side that is not last_owner.
    always_comb begin
        w_grant_fill  = 1'b0;
        w_grant_owner = OWN_I;
        if (i_miss_req && d_miss_req) begin
            w_grant_fill  = 1'b1;
            w_grant_owner = (r_last_owner == OWN_I) ? OWN_D : OWN_I;
        end else if (d_miss_req) begin
            w_grant_fill  = 1'b1;
            w_grant_owner = OWN_D;
        end else if (i_miss_req) begin
            w_grant_fill  = 1'b1;
            w_grant_owner = OWN_I;
        end else begin
            w_grant_fill  = 1'b0;
            w_grant_owner = OWN_I;
        end
        w_grant_base = ((w_grant_owner == OWN_D) ? d_miss_addr : i_miss_addr) & BASE_MASK;
    end

    // Address of the next read in the block, byte-addressed at 2 bytes per word.
    always_comb begin
        w_issue_nxt      = r_issue_cnt + CNT_W'(1'b1);
        w_issue_addr_nxt = r_base + ADDR_W'({w_issue_nxt, 1'b0});
    end

    // Fill return path; gated by rst_n so an aborted fill never reports a word or done.
    always_comb begin
        w_fill_act  = rst_n && (r_state == ST_FILL) && mem_data_valid;
        w_fill_last = w_fill_act && (r_recv_cnt == RECV_LAST);
        i_fill_we   = w_fill_act && (r_owner == OWN_I);
        d_fill_we   = w_fill_act && (r_owner == OWN_D);
        i_fill_done = w_fill_last && (r_owner == OWN_I);
        d_fill_done = w_fill_last && (r_owner == OWN_D);
        fill_word   = w_fill_act ? r_recv_cnt : {WIDX_W{1'b0}};
        fill_data   = w_fill_act ? mem_data_in : {DATA_W{1'b0}};
    end

    // Main sequencer: state, counters and registered memory-port outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_owner        <= OWN_I;
            r_last_owner   <= OWN_I;
            r_base         <= {ADDR_W{1'b0}};
            r_issue_cnt    <= {CNT_W{1'b0}};
            r_recv_cnt     <= {WIDX_W{1'b0}};
            r_mem_enable   <= 1'b0;
            r_mem_wr       <= 1'b0;
            r_mem_addr     <= {ADDR_W{1'b0}};
            r_mem_data_out <= {DATA_W{1'b0}};
            r_wr_ack       <= 1'b0;
        end else begin
            r_wr_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (d_wr_req) begin
                        r_state        <= ST_WRITE;
                        r_mem_enable   <= 1'b1;
                        r_mem_wr       <= 1'b1;
                        r_mem_addr     <= d_wr_addr;
                        r_mem_data_out <= d_wr_data;
                        r_wr_ack       <= 1'b1;
                    end else if (w_grant_fill) begin
                        // last_owner takes the owner being displaced by this grant.
                        r_state        <= ST_FILL;
                        r_last_owner   <= r_owner;
                        r_owner        <= w_grant_owner;
                        r_base         <= w_grant_base;
                        r_issue_cnt    <= {CNT_W{1'b0}};
                        r_recv_cnt     <= {WIDX_W{1'b0}};
                        r_mem_enable   <= 1'b1;
                        r_mem_wr       <= 1'b0;
                        r_mem_addr     <= w_grant_base;
                        r_mem_data_out <= {DATA_W{1'b0}};
                    end else begin
                        r_mem_enable   <= 1'b0;
                        r_mem_wr       <= 1'b0;
                        r_mem_addr     <= {ADDR_W{1'b0}};
                        r_mem_data_out <= {DATA_W{1'b0}};
                    end
                end
                ST_WRITE: begin
                    r_state        <= ST_IDLE;
                    r_mem_enable   <= 1'b0;
                    r_mem_wr       <= 1'b0;
                    r_mem_addr     <= {ADDR_W{1'b0}};
                    r_mem_data_out <= {DATA_W{1'b0}};
                end
                ST_FILL: begin
                    if (r_issue_cnt < ISSUE_END) begin
                        r_issue_cnt <= w_issue_nxt;
                        if (r_issue_cnt < ISSUE_LAST) begin
                            r_mem_enable <= 1'b1;
                            r_mem_addr   <= w_issue_addr_nxt;
                        end else begin
                            r_mem_enable <= 1'b0;
                            r_mem_addr   <= {ADDR_W{1'b0}};
                        end
                    end else begin
                        r_mem_enable <= 1'b0;
                        r_mem_addr   <= {ADDR_W{1'b0}};
                    end
                    r_mem_wr <= 1'b0;
                    if (w_fill_act) begin
                        r_recv_cnt <= r_recv_cnt + WIDX_W'(1'b1);
                        if (w_fill_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_FILL;
                        end
                    end else begin
                        r_recv_cnt <= r_recv_cnt;
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_mem_enable   <= 1'b0;
                    r_mem_wr       <= 1'b0;
                    r_mem_addr     <= {ADDR_W{1'b0}};
                    r_mem_data_out <= {DATA_W{1'b0}};
                end
            endcase
        end
    end

    assign mem_enable   = r_mem_enable;
    assign mem_wr       = r_mem_wr;
    assign mem_addr     = r_mem_addr;
    assign mem_data_out = r_mem_data_out;
    assign d_wr_ack     = r_wr_ack;
    assign i_stall      = i_miss_req & ~i_fill_done;
    assign d_stall      = (d_miss_req & ~d_fill_done) | (d_wr_req & ~d_wr_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked cycle by
// cycle against a transaction-level model and a latency-4 pipelined memory.
module tb_mem_arbiter;

    localparam int MEM_LATENCY = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_miss_req, d_miss_req, d_wr_req;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_data_out, mem_data_in;
    logic        mem_data_valid;
    logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        i_stall, d_stall;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
        .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
        .mem_data_valid(mem_data_valid),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we), .fill_word(fill_word),
        .fill_data(fill_data), .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
        .d_wr_ack(d_wr_ack), .i_stall(i_stall), .d_stall(d_stall)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [15:0] addr; } rd_t;
    rd_t rd_q[$];
    int  done_log[$];

    int n_checks = 0, n_errors = 0, cyc = 0;
    int m_mode, m_k, m_got;
    bit m_owner, m_last;
    logic [15:0] m_base;
    int n_idone = 0, last_idone_cyc = -1, last_ddone_cyc = -1, last_ack_cyc = -1;
    logic [15:0] last_wr_addr = 16'h0, last_wr_data = 16'h0;
    bit rand_mode = 1'b0, inject_valid = 1'b0;
    int c0, n0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] memval(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic int dlog(input int k);
        return (done_log.size() > k) ? done_log[k] : 9;
    endfunction

    // One clock cycle: memory response, expected outputs, compare, model update, advance.
    task automatic step();
        logic        e_en, e_wr, e_ife, e_dfe, e_idn, e_ddn, e_ack, w;
        logic [15:0] e_addr, e_dout, e_data;
        logic [2:0]  e_word;
        bit          g, drop_i, drop_d, drop_w;
        rd_t         r;
        mem_data_valid = 1'b0;
        mem_data_in    = 16'h0;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            mem_data_valid = 1'b1;
            mem_data_in    = memval(rd_q[0].addr);
            void'(rd_q.pop_front());
        end else if (inject_valid && m_mode == 0) begin
            mem_data_valid = 1'b1;
            mem_data_in    = 16'h5A5A;
        end
        #1;
        {e_en, e_wr, e_ife, e_dfe, e_idn, e_ddn, e_ack, w} = 8'h00;
        e_addr = 16'h0; e_dout = 16'h0; e_data = 16'h0; e_word = 3'd0;
        if (m_mode == 1) begin
            e_en = 1'b1; e_wr = 1'b1; e_addr = d_wr_addr; e_dout = d_wr_data; e_ack = 1'b1;
        end else if (m_mode == 2) begin
            if (m_k < 8) begin
                e_en = 1'b1; e_addr = m_base + 16'(2 * m_k);
            end
            if (rst_n && mem_data_valid) begin
                w = 1'b1; e_word = 3'(m_got); e_data = memval(m_base + 16'(2 * m_got));
                if (m_owner) e_dfe = 1'b1; else e_ife = 1'b1;
                if (m_got == 7) begin
                    if (m_owner) e_ddn = 1'b1; else e_idn = 1'b1;
                end
            end
        end
        chk("mem_enable", mem_enable, e_en);
        chk("mem_wr", mem_wr, e_wr);
        chk("mem_addr", e_en ? mem_addr : 16'h0, e_addr);
        if (e_wr) chk("mem_data_out", mem_data_out, e_dout);
        chk("i_fill_we", i_fill_we, e_ife);
        chk("d_fill_we", d_fill_we, e_dfe);
        if (w) begin
            chk("fill_word", fill_word, e_word);
            chk("fill_data", fill_data, e_data);
        end
        chk("i_fill_done", i_fill_done, e_idn);
        chk("d_fill_done", d_fill_done, e_ddn);
        chk("d_wr_ack", d_wr_ack, e_ack);
        chk("i_stall", i_stall, i_miss_req & ~e_idn);
        chk("d_stall", d_stall, (d_miss_req & ~e_ddn) | (d_wr_req & ~e_ack));

        if (i_fill_done) begin n_idone++; last_idone_cyc = cyc; done_log.push_back(0); end
        if (d_fill_done) begin last_ddone_cyc = cyc; done_log.push_back(1); end
        if (d_wr_ack) begin last_ack_cyc = cyc; last_wr_addr = mem_addr; last_wr_data = mem_data_out; end
        if (mem_enable && !mem_wr) begin
            r.due = cyc + MEM_LATENCY; r.addr = mem_addr; rd_q.push_back(r);
        end

        if (!rst_n) begin
            m_mode = 0; m_owner = 1'b0; m_last = 1'b0; rd_q.delete();
        end else if (m_mode == 0) begin
            if (d_wr_req) begin
                m_mode = 1;
            end else if (i_miss_req || d_miss_req) begin
                g = (i_miss_req && d_miss_req) ? !m_last : d_miss_req;
                m_last = m_owner;   // last_owner remembers the owner being replaced
                m_owner = g;
                m_base = (g ? d_miss_addr : i_miss_addr) & 16'hFFF0;
                m_k = 0; m_got = 0; m_mode = 2;
            end
        end else if (m_mode == 1) begin
            m_mode = 0;
        end else begin
            if (w) begin
                if (m_got == 7) begin
                    chk("done_k", m_k, 7 + MEM_LATENCY);
                    m_mode = 0;
                end
                m_got++;
            end
            m_k++;
        end
        drop_i = e_idn; drop_d = e_ddn; drop_w = e_ack;

        @(posedge clk);
        #1;
        cyc++;
        if (drop_i) i_miss_req = 1'b0;
        if (drop_d) d_miss_req = 1'b0;
        if (drop_w) d_wr_req = 1'b0;
        if (rand_mode) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if (!i_miss_req && !drop_i && $urandom_range(0, 7) == 0) begin
                i_miss_req = 1'b1; i_miss_addr = 16'($urandom);
            end
            if (!d_miss_req && !drop_d && $urandom_range(0, 9) == 0) begin
                d_miss_req = 1'b1; d_miss_addr = 16'($urandom);
            end
            if (!d_wr_req && !drop_w && $urandom_range(0, 11) == 0) begin
                d_wr_req = 1'b1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
            end
        end
        inject_valid = rand_mode ? ($urandom_range(0, 15) == 0) : 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n = 1'b0;
        {i_miss_req, d_miss_req, d_wr_req} = 3'b000;
        i_miss_addr = 16'h0; d_miss_addr = 16'h0; d_wr_addr = 16'h0; d_wr_data = 16'h0;
        mem_data_valid = 1'b0; mem_data_in = 16'h0;
        m_mode = 0; m_owner = 1'b0; m_last = 1'b0; m_k = 0; m_got = 0; m_base = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_enable", mem_enable, 1'b0);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_mem_data_out", mem_data_out, 16'h0);
        chk("rst_fill_we", {i_fill_we, d_fill_we}, 2'b00);
        chk("rst_done", {i_fill_done, d_fill_done}, 2'b00);
        chk("rst_ack", d_wr_ack, 1'b0);
        rst_n = 1'b1;

        // simultaneous misses right after reset: D first, then I
        i_miss_addr = 16'h0124; d_miss_addr = 16'h3008;
        i_miss_req = 1'b1; d_miss_req = 1'b1;
        run(30);
        chk("tie_first_is_d", dlog(0), 1);
        chk("tie_second_is_i", dlog(1), 0);
        chk("tie_i_after_d", last_idone_cyc - last_ddone_cyc, 13);
        i_miss_req = 1'b1; d_miss_req = 1'b1;
        run(30);
        chk("pair_first_is_i", dlog(2), 0);
        chk("pair_second_is_d", dlog(3), 1);

        c0 = cyc; i_miss_addr = 16'h0124; i_miss_req = 1'b1;
        run(16);
        chk("lone_i_done_cyc", last_idone_cyc, c0 + 12);

        // store raised in FILL k=3 waits for the fill
        c0 = cyc; i_miss_req = 1'b1;
        run(4);
        d_wr_addr = 16'h4002; d_wr_data = 16'hBEEF; d_wr_req = 1'b1;
        run(16);
        chk("st_done_cyc", last_idone_cyc, c0 + 12);
        chk("st_ack_gap", last_ack_cyc - last_idone_cyc, 2);
        chk("st_addr", last_wr_addr, 16'h4002);
        chk("st_data", last_wr_data, 16'hBEEF);

        c0 = cyc; d_wr_addr = 16'h0456; d_wr_data = 16'h1234; d_wr_req = 1'b1;
        d_miss_addr = 16'h777A; d_miss_req = 1'b1;
        run(20);
        chk("wd_ack_cyc", last_ack_cyc, c0 + 1);
        chk("wd_fill_gap", last_ddone_cyc - last_ack_cyc, 13);

        // reset in FILL k=6, miss held through it
        c0 = cyc; i_miss_addr = 16'h0A5C; i_miss_req = 1'b1;
        run(7);
        n0 = n_idone; rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        chk("rst_mid_enable", mem_enable, 1'b0);
        chk("rst_mid_ack", d_wr_ack, 1'b0);
        run(16);
        chk("rst_one_done", n_idone - n0, 1);
        chk("rst_done_cyc", last_idone_cyc, c0 + 20);

        inject_valid = 1'b1;
        run(1);
        c0 = cyc; d_miss_addr = 16'h1238; d_miss_req = 1'b1;
        run(16);
        chk("idle_valid_then_fill", last_ddone_cyc, c0 + 12);

        rand_mode = 1'b1;
        run(3000);
        rand_mode = 1'b0; rst_n = 1'b1;
        run(60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
